// File: rtl/max_unpooling_unit_pkg.sv
// Shared definitions for the max-unpooling slice: FSM state encoding and index helpers.
// UNPOOL_NEAREST_EN is left undefined by default (max-unpool behaviour).
package max_unpooling_unit_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } unpool_state_t;

   function automatic logic idx_in_range(input int unsigned idx, input int unsigned size);
      return idx < size;
   endfunction

endpackage

// File: rtl/max_unpooling_unit_if.sv
// Pooled-beat input and window-element output streams of the max-unpooling unit.
interface max_unpooling_unit_if #(
   parameter int SIZE    = 4,
   parameter int D_WIDTH = 16
);
   localparam int IDX_W = $clog2(SIZE);

   logic               in_valid;
   logic               in_ready;
   logic [D_WIDTH-1:0] in_data;
   logic [IDX_W-1:0]   in_index;
   logic               out_valid;
   logic               out_ready;
   logic [D_WIDTH-1:0] out_data;
   logic [IDX_W-1:0]   out_pos;
   logic               out_last;
   logic               idx_err;

   modport master (
      output in_valid, in_data, in_index, out_ready,
      input  in_ready, out_valid, out_data, out_pos, out_last, idx_err
   );

   modport slave (
      input  in_valid, in_data, in_index, out_ready,
      output in_ready, out_valid, out_data, out_pos, out_last, idx_err
   );
endinterface

// File: rtl/max_unpooling_unit_counter.sv
// Modulo-SIZE window position counter; clear has priority over advance.
module unpool_window_counter #(
   parameter  int SIZE  = 4,
   localparam int IDX_W = $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             advance,
   output logic [IDX_W-1:0] pos,
   output logic             last
);
   localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(SIZE - 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos <= '0;
      end else if (clear) begin
         pos <= '0;
      end else if (advance) begin
         pos <= last ? '0 : pos + 1'b1;
      end
   end

   assign last = (pos == LAST_POS);

endmodule

// File: rtl/max_unpooling_unit.sv
// Streams each pooled beat back out as a SIZE-element window (value at argmax, zeros elsewhere).
// Define UNPOOL_NEAREST_EN to repeat the value across the whole window instead.
module max_unpooling_unit
   import max_unpooling_unit_pkg::*;
#(
   parameter int SIZE    = 4,
   parameter int D_WIDTH = 16
) (
   input  logic            clk,
   input  logic            reset,
   max_unpooling_unit_if.slave bus
);
   localparam int IDX_W = $clog2(SIZE);

   unpool_state_t      state;
   logic [D_WIDTH-1:0] value_q;
   logic [IDX_W-1:0]   pos;
   logic               last;
   logic               ready;
   logic               accept;
   logic               out_hs;

   // Ready on the final element so the next beat follows without a bubble.
   assign ready  = (state == IDLE) || ((state == EMIT) && last && bus.out_ready);
   assign accept = bus.in_valid && ready;
   assign out_hs = (state == EMIT) && bus.out_ready;

   unpool_window_counter #(.SIZE(SIZE)) u_counter (
      .clk     (clk),
      .reset   (reset),
      .clear   (accept),
      .advance (out_hs),
      .pos     (pos),
      .last    (last)
   );

`ifdef UNPOOL_NEAREST_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         value_q <= '0;
      end else if (accept) begin
         state   <= EMIT;
         value_q <= bus.in_data;
      end else if (out_hs && last) begin
         state   <= IDLE;
      end
   end

   assign bus.out_data = (state == EMIT) ? value_q : '0;
   assign bus.idx_err  = 1'b0;
`else
   logic [IDX_W-1:0] index_q;
   logic             err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         value_q <= '0;
         index_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         state   <= EMIT;
         value_q <= bus.in_data;
         index_q <= bus.in_index;
         if (!idx_in_range(32'(bus.in_index), SIZE)) begin
            err_q <= 1'b1;
         end
      end else if (out_hs && last) begin
         state   <= IDLE;
      end
   end

   // An out-of-range index never matches pos, so that window comes out all zero.
   assign bus.out_data = ((state == EMIT) && (pos == index_q)) ? value_q : '0;
   assign bus.idx_err  = err_q;
`endif

   assign bus.in_ready  = ready;
   assign bus.out_valid = (state == EMIT);
   assign bus.out_pos   = pos;
   assign bus.out_last  = (state == EMIT) && last;

endmodule
